// File: rtl/compute_issue_arbiter.sv
// compute_issue_arbiter: shares one compute unit between two instruction
// requesters. Round-robin arbitration with an optional bounded lock; each
// 8-bit result is routed back to the requester that issued the instruction
// three cycles after acceptance.
module compute_issue_arbiter #(
  parameter int unsigned MAX_LOCK = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [15:0] req0_instr,
  input  logic        req0_lock,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [15:0] req1_instr,
  input  logic        req1_lock,
  output logic        req1_ready,
  output logic        cu_ena,
  output logic [15:0] cu_instr,
  input  logic [7:0]  cu_result,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  output logic [7:0]  rsp_data
);

  localparam logic [3:0] MAX_LOCK_C = 4'(MAX_LOCK);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        rr_q, rr_d;
  logic [3:0]  lock_cnt_q, lock_cnt_d;

  logic        gnt0, gnt1;
  logic        xfer, xfer_id, xfer_lock;
  logic [15:0] xfer_instr;

  logic        vld_p0_q, vld_p0_d;
  logic        id_p0_q, id_p0_d;
  logic [15:0] cu_instr_q, cu_instr_d;
  logic        vld_p1_q, vld_p1_d;
  logic        id_p1_q, id_p1_d;
  logic        rsp0_valid_q, rsp0_valid_d;
  logic        rsp1_valid_q, rsp1_valid_d;
  logic [7:0]  rsp_data_q, rsp_data_d;

  // Arbitration state register: owner state, round-robin pointer, lock count
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rr_q       <= 1'b0;
      lock_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  // Grant decode: the lock owner is served exclusively, otherwise round-robin
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_IDLE: begin
          if (req0_valid && req1_valid) begin
            gnt0 = !rr_q;
            gnt1 = rr_q;
          end else begin
            gnt0 = req0_valid;
            gnt1 = req1_valid;
          end
        end
        ST_LOCK0: gnt0 = req0_valid;
        ST_LOCK1: gnt1 = req1_valid;
        default: begin
          gnt0 = 1'b0;
          gnt1 = 1'b0;
        end
      endcase
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign xfer       = gnt0 | gnt1;
  assign xfer_id    = gnt1;
  assign xfer_instr = gnt1 ? req1_instr : req0_instr;
  assign xfer_lock  = gnt1 ? req1_lock : req0_lock;

  // Next-state: acquire lock on a locked transfer, release on unlock, cap or valid drop
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    lock_cnt_d = lock_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          rr_d = !xfer_id;
          // A cap of one means the acquiring transfer is also the last one
          if (xfer_lock && (MAX_LOCK_C > 4'd1)) begin
            state_d    = xfer_id ? ST_LOCK1 : ST_LOCK0;
            lock_cnt_d = 4'd1;
          end
        end
      end
      ST_LOCK0, ST_LOCK1: begin
        if (xfer && xfer_lock && ((lock_cnt_q + 4'd1) != MAX_LOCK_C)) begin
          lock_cnt_d = lock_cnt_q + 4'd1;
        end else begin
          state_d    = ST_IDLE;
          lock_cnt_d = 4'd0;
          rr_d       = (state_q == ST_LOCK0);
        end
      end
      default: begin
        state_d    = ST_IDLE;
        lock_cnt_d = 4'd0;
      end
    endcase
  end

  // Issue and response-tag datapath: transfer -> p0 (issue) -> p1 (result) -> response
  always_comb begin
    vld_p0_d     = xfer;
    id_p0_d      = xfer_id;
    cu_instr_d   = xfer ? xfer_instr : 16'h0000;
    vld_p1_d     = vld_p0_q;
    id_p1_d      = id_p0_q;
    rsp0_valid_d = vld_p1_q && !id_p1_q;
    rsp1_valid_d = vld_p1_q && id_p1_q;
    rsp_data_d   = vld_p1_q ? cu_result : rsp_data_q;
  end

  // Pipeline registers; reset drops in-flight tags so no stale response appears
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0_q     <= 1'b0;
      id_p0_q      <= 1'b0;
      cu_instr_q   <= 16'h0000;
      vld_p1_q     <= 1'b0;
      id_p1_q      <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp_data_q   <= 8'h00;
    end else begin
      vld_p0_q     <= vld_p0_d;
      id_p0_q      <= id_p0_d;
      cu_instr_q   <= cu_instr_d;
      vld_p1_q     <= vld_p1_d;
      id_p1_q      <= id_p1_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  assign cu_ena     = vld_p0_q;
  assign cu_instr   = cu_instr_q;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp_data   = rsp_data_q;

endmodule

// File: tb/tb_compute_issue_arbiter.sv
// Scoreboard bench for compute_issue_arbiter with a stand-in compute unit.
module tb_compute_issue_arbiter;
  localparam int MAX_LOCK = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req0_lock = 1'b0, req0_ready;
  logic        req1_valid = 1'b0, req1_lock = 1'b0, req1_ready;
  logic [15:0] req0_instr = 16'h0, req1_instr = 16'h0, cu_instr;
  logic        cu_ena, rsp0_valid, rsp1_valid;
  logic [7:0]  cu_result = 8'h0, rsp_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  compute_issue_arbiter #(.MAX_LOCK(MAX_LOCK)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_instr(req0_instr), .req0_lock(req0_lock), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_instr(req1_instr), .req1_lock(req1_lock), .req1_ready(req1_ready),
    .cu_ena(cu_ena), .cu_instr(cu_instr), .cu_result(cu_result),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_data(rsp_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in compute unit: op1 loads an immediate, op2 adds two registers,
  // anything else answers with the XOR of the instruction bytes.
  logic [7:0] cu_regs [16];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) cu_regs[i] <= 8'h0;
      cu_result <= 8'h0;
    end else if (cu_ena) begin
      case (cu_instr[15:12])
        4'h1: begin
          cu_regs[cu_instr[11:8]] <= cu_instr[7:0];
          cu_result <= cu_instr[7:0];
        end
        4'h2: begin
          cu_regs[cu_instr[11:8]] <= cu_regs[cu_instr[7:4]] + cu_regs[cu_instr[3:0]];
          cu_result <= cu_regs[cu_instr[7:4]] + cu_regs[cu_instr[3:0]];
        end
        default: cu_result <= cu_instr[15:8] ^ cu_instr[7:0];
      endcase
    end
  end

  // Reference model state
  logic [7:0] m_regs [16];
  int m_owner = -1;
  int m_cnt = 0;
  int m_pref = 0;

  typedef struct { int id; logic [7:0] data; int due; } rsp_t;
  typedef struct { logic [15:0] instr; int due; } iss_t;
  rsp_t rsp_q[$];
  iss_t iss_q[$];

  logic [15:0] s0_instr[$], s1_instr[$];
  bit          s0_lock[$], s1_lock[$];
  int          s0_gap[$], s1_gap[$];
  int          n_acc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s cyc=%0d", name, cyc);
  endtask

  function automatic logic [7:0] model_exec(input logic [15:0] ins);
    logic [7:0] r;
    if (ins[15:12] == 4'h1) begin
      r = ins[7:0];
      m_regs[ins[11:8]] = r;
    end else if (ins[15:12] == 4'h2) begin
      r = m_regs[ins[7:4]] + m_regs[ins[3:0]];
      m_regs[ins[11:8]] = r;
    end else begin
      r = ins[15:8] ^ ins[7:0];
    end
    return r;
  endfunction

  task automatic push(input int n, input logic [15:0] ins, input bit lk, input int gap);
    if (n == 0) begin
      s0_instr.push_back(ins); s0_lock.push_back(lk); s0_gap.push_back(gap);
    end else begin
      s1_instr.push_back(ins); s1_lock.push_back(lk); s1_gap.push_back(gap);
    end
  endtask

  // One cycle of stimulus: present heads of the sources, predict the grant,
  // and on a transfer push the expected issue and response.
  task automatic step(input bit do_rst);
    bit v0, v1, e0, e1, lk;
    int g;
    logic [15:0] ins;
    logic [7:0] r;
    rsp_t er;
    iss_t ei;
    v0 = (s0_instr.size() > 0) && (s0_gap[0] == 0);
    v1 = (s1_instr.size() > 0) && (s1_gap[0] == 0);
    if (!v0 && s0_instr.size() > 0) s0_gap[0] = s0_gap[0] - 1;
    if (!v1 && s1_instr.size() > 0) s1_gap[0] = s1_gap[0] - 1;
    rst = do_rst;
    req0_valid = v0; req0_instr = v0 ? s0_instr[0] : 16'h0; req0_lock = v0 ? s0_lock[0] : 1'b0;
    req1_valid = v1; req1_instr = v1 ? s1_instr[0] : 16'h0; req1_lock = v1 ? s1_lock[0] : 1'b0;
    #1;
    e0 = 1'b0; e1 = 1'b0;
    if (!do_rst) begin
      if (m_owner == 0) e0 = v0;
      else if (m_owner == 1) e1 = v1;
      else if (v0 && v1) begin e0 = (m_pref == 0); e1 = (m_pref == 1); end
      else begin e0 = v0; e1 = v1; end
    end
    check("req0_ready", req0_ready, e0);
    check("req1_ready", req1_ready, e1);
    g = e0 ? 0 : (e1 ? 1 : -1);
    lk = 1'b0;
    if (do_rst) begin
      m_owner = -1; m_cnt = 0; m_pref = 0;
      for (int i = 0; i < 16; i++) m_regs[i] = 8'h0;
      while (rsp_q.size() > 0 && rsp_q[rsp_q.size()-1].due > cyc) void'(rsp_q.pop_back());
      while (iss_q.size() > 0 && iss_q[iss_q.size()-1].due > cyc) void'(iss_q.pop_back());
    end else begin
      if (g >= 0) begin
        ins = (g == 1) ? s1_instr[0] : s0_instr[0];
        lk  = (g == 1) ? s1_lock[0] : s0_lock[0];
        r = model_exec(ins);
        er.id = g; er.data = r; er.due = cyc + 3; rsp_q.push_back(er);
        ei.instr = ins; ei.due = cyc + 1; iss_q.push_back(ei);
        n_acc++;
        if (g == 0) begin
          void'(s0_instr.pop_front()); void'(s0_lock.pop_front()); void'(s0_gap.pop_front());
        end else begin
          void'(s1_instr.pop_front()); void'(s1_lock.pop_front()); void'(s1_gap.pop_front());
        end
      end
      if (m_owner >= 0) begin
        if (g == m_owner && lk) m_cnt++;
        if (!(g == m_owner && lk) || m_cnt >= MAX_LOCK) begin
          m_pref = 1 - m_owner; m_owner = -1; m_cnt = 0;
        end
      end else if (g >= 0) begin
        m_pref = 1 - g;
        if (lk && MAX_LOCK > 1) begin m_owner = g; m_cnt = 1; end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while ((s0_instr.size() > 0 || s1_instr.size() > 0) && n < bound) begin
      step(1'b0);
      n++;
    end
    if (n >= bound) fail("source_stall");
    repeat (5) step(1'b0);
  endtask

  task automatic do_reset();
    step(1'b1);
    step(1'b1);
  endtask

  // Monitor: pops the scoreboard whenever the DUT issues or responds
  rsp_t       mon_r;
  iss_t       mon_i;
  logic [7:0] exp_data = 8'h0;
  always @(negedge clk) begin
    if (mon_en) begin
      check("rsp_exclusive", {31'b0, rsp0_valid && rsp1_valid}, 32'd0);
      if (rsp0_valid || rsp1_valid) begin
        if (rsp_q.size() == 0) fail("rsp_unexpected");
        else begin
          mon_r = rsp_q.pop_front();
          check("rsp_id", {31'b0, rsp1_valid}, mon_r.id);
          check("rsp_data", rsp_data, mon_r.data);
          check("rsp_latency", cyc, mon_r.due);
          exp_data = mon_r.data;
        end
      end else begin
        if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
          fail("rsp_missing");
          void'(rsp_q.pop_front());
        end
        check("rsp_data_hold", rsp_data, exp_data);
      end
      if (cu_ena) begin
        if (iss_q.size() == 0) fail("issue_unexpected");
        else begin
          mon_i = iss_q.pop_front();
          check("cu_instr", cu_instr, mon_i.instr);
          check("issue_latency", cyc, mon_i.due);
        end
      end else begin
        if (iss_q.size() > 0 && iss_q[0].due <= cyc) begin
          fail("issue_missing");
          void'(iss_q.pop_front());
        end
        check("cu_instr_idle", cu_instr, 16'h0);
      end
      if (rst) exp_data = 8'h0;
    end
  end

  initial begin
    @(posedge clk); #1;
    step(1'b1);
    mon_en = 1'b1;
    step(1'b1);
    repeat (2) step(1'b0);

    // Single requester, load/load/add
    push(0, 16'h1105, 1'b0, 0);
    push(0, 16'h1203, 1'b0, 0);
    push(0, 16'h2312, 1'b0, 0);
    drain(50);

    // Contention without lock, both valid from reset
    do_reset();
    for (int i = 0; i < 8; i++) begin
      push(0, 16'($urandom), 1'b0, 0);
      push(1, 16'($urandom), 1'b0, 0);
    end
    drain(100);

    // req1 locks for three then releases while req0 waits
    do_reset();
    push(0, 16'h1a11, 1'b0, 1);
    for (int i = 0; i < 3; i++) push(0, 16'($urandom), 1'b0, 0);
    for (int i = 0; i < 3; i++) push(1, 16'($urandom), 1'b1, 0);
    push(1, 16'h1b22, 1'b0, 0);
    drain(100);

    // Lock cap: req0 holds lock continuously
    do_reset();
    for (int i = 0; i < 12; i++) push(0, 16'($urandom), 1'b1, 0);
    for (int i = 0; i < 3; i++) push(1, 16'($urandom), 1'b0, 0);
    drain(100);

    // Owner drops valid for one cycle inside LOCK0
    do_reset();
    push(0, 16'h1c01, 1'b1, 0);
    push(0, 16'h1d02, 1'b1, 0);
    push(0, 16'h1e03, 1'b1, 1);
    push(0, 16'h1f04, 1'b0, 0);
    push(1, 16'h1005, 1'b0, 0);
    push(1, 16'h1106, 1'b0, 0);
    drain(100);

    // Reset in the cycle after two accepts
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push(0, 16'($urandom), 1'b0, 0);
      push(1, 16'($urandom), 1'b0, 0);
    end
    begin
      int start, n;
      start = n_acc;
      n = 0;
      while (n_acc - start < 2 && n < 20) begin step(1'b0); n++; end
      if (n >= 20) fail("accept_stall");
    end
    step(1'b1);
    drain(100);

    // Randomized traffic with locks and valid gaps
    do_reset();
    for (int i = 0; i < 150; i++) begin
      for (int n = 0; n < 2; n++) begin
        push(n, {4'($urandom_range(0, 3)), 12'($urandom)},
             ($urandom_range(0, 9) < 4),
             ($urandom_range(0, 9) < 3) ? int'($urandom_range(1, 3)) : 0);
      end
    end
    drain(3000);

    check("scoreboard_empty", rsp_q.size() + iss_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
